multi_dev_bridge: RTL and testbench
===================================

MULTI_DEV_BRIDGE -- requirements
Module: multi_dev_bridge

Interface
REQ-001 SHALL have parameter NUM_DEV, default 3: number of attached devices (2..8).
REQ-002 SHALL have parameter DATA_W, default 32: data width; ADDR_W, default 32: address width.
REQ-003 SHALL have parameter SEL_LSB, default 4: lowest address bit of the device-index field; field width SEL_W = clog2(NUM_DEV).
REQ-004 SHALL have parameter TIMEOUT_CYC, default 15: maximum cycles in ACCESS before abort.
REQ-005 Ports:
- clk in 1: single clock, rising edge.
- reset in 1: asynchronous, active-high.
- cpu_req in 1: request, level, held until cpu_ack.
- cpu_we in 1: write request.
- cpu_be in DATA_W/8: byte enables.
- cpu_addr in ADDR_W: address.
- cpu_wdata in DATA_W: write data.
- cpu_rdata out DATA_W: read data, valid with cpu_ack.
- cpu_ack out 1: one-cycle completion pulse.
- cpu_err out 1: error flag, valid with cpu_ack.
- dev_addr out ADDR_W: latched address, shared.
- dev_wdata out DATA_W: latched write data, shared.
- dev_be out DATA_W/8: latched byte enables.
- dev_we out 1: write strobe, qualified by dev_sel.
- dev_sel out NUM_DEV: one-hot device select.
- dev_rdata in NUM_DEV*DATA_W: packed read data, device i at [i*DATA_W +: DATA_W].
- dev_ready in NUM_DEV: per-device completion.
- dev_irq in NUM_DEV: device interrupt lines.
- hwint out NUM_DEV: registered interrupt vector.

Function
REQ-006 FSM states IDLE, ACCESS, RESP; reset state IDLE.
REQ-007 IDLE with cpu_req=1: latch addr/wdata/be/we; idx = cpu_addr[SEL_LSB +: SEL_W]; idx < NUM_DEV -> ACCESS; else -> RESP with err=1, no dev_sel.
REQ-008 ACCESS: dev_sel[idx]=1, dev_we = latched we; all other dev_sel bits 0; latched fields stable.
REQ-009 ACCESS with dev_ready[idx]=1: capture dev_rdata[idx] (reads; writes capture 0) -> RESP, err=0.
REQ-010 dev_ready of non-selected devices ignored.
REQ-011 RESP: cpu_ack=1 for exactly one cycle, then IDLE unconditionally; cpu_req ignored in RESP.
REQ-012 Minimum latency: req sampled cycle t, dev_sel at t+1, ready at t+1 -> ack at t+2.
REQ-013 cpu_rdata/cpu_err hold their value until the next RESP; error responses drive cpu_rdata=0.
REQ-014 Back-to-back: cpu_req still high in the IDLE cycle after RESP starts a new transaction.
REQ-015 hwint = dev_irq registered, one-cycle latency, no masking.

Reset
REQ-016 reset=1 asynchronously forces IDLE; cpu_ack, cpu_err, dev_sel, dev_we, hwint = 0; cpu_rdata, dev_addr, dev_wdata, dev_be = 0; timeout counter = 0.
REQ-017 Reset during ACCESS aborts without ack; the device sees dev_sel fall that cycle.

Configuration
REQ-018 BRIDGE_TIMEOUT_EN defined: counter clears on ACCESS entry, increments each ACCESS cycle without ready; reaching TIMEOUT_CYC -> RESP, err=1, rdata=0; ready at the same edge as the limit wins (err=0).
REQ-019 BRIDGE_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely for ready; TIMEOUT_CYC unused.

Structure
REQ-020 Package bridge_pkg SHALL hold the state enum (IDLE/ACCESS/RESP) and default parameter constants.
REQ-021 Timeout counter SHALL be sub-module bridge_wdog (clear, count-enable, expired), instantiated only under BRIDGE_TIMEOUT_EN.

Verification
REQ-022 Read, addr 0x0000_0010 (dev1), dev1 ready at t+1, rdata 0xDEAD_BEEF -> ack at t+2, cpu_rdata 0xDEAD_BEEF, err 0.
REQ-023 Write, addr 0x0000_0004, wdata 0x1234_5678, be 4'hF -> dev_sel=3'b001 and dev_we=1 for the ACCESS cycles only; dev_wdata 0x1234_5678.
REQ-024 Addr 0x0000_0030 (idx 3 ≥ NUM_DEV=3) -> dev_sel stays 0, ack at t+1, err 1, rdata 0.
REQ-025 TIMEOUT_EN, dev2 never ready -> ack after 15 ACCESS cycles, err 1; ready on cycle 15 -> err 0.
REQ-026 Reset asserted mid-ACCESS -> dev_sel, ack 0 immediately; next req completes normally.
REQ-027 dev_irq=3'b101 at cycle t -> hwint=3'b101 at t+1.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared types and default constants for the multi-device bus bridge.
// Optional access watchdog is enabled by defining BRIDGE_TIMEOUT_EN.
package bridge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam int DEF_NUM_DEV     = 3;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_SEL_LSB     = 4;
    localparam int DEF_TIMEOUT_CYC = 15;

endpackage

// File: rtl/bridge_wdog.sv
// Access watchdog: counts stalled ACCESS cycles, flags the final one.
// Only instantiated when BRIDGE_TIMEOUT_EN is defined.
module bridge_wdog #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // High during the LIMIT-th stalled cycle, so the abort lands on that edge
    assign expired = (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/multi_dev_bridge.sv
// CPU-to-N-device bridge: decodes a device index from the address and
// runs one access at a time. Define BRIDGE_TIMEOUT_EN to abort stalled accesses.
module multi_dev_bridge
    import bridge_pkg::*;
#(
    parameter int NUM_DEV     = DEF_NUM_DEV,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int SEL_LSB     = DEF_SEL_LSB,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cpu_req,
    input  logic                      cpu_we,
    input  logic [DATA_W/8-1:0]       cpu_be,
    input  logic [ADDR_W-1:0]         cpu_addr,
    input  logic [DATA_W-1:0]         cpu_wdata,
    output logic [DATA_W-1:0]         cpu_rdata,
    output logic                      cpu_ack,
    output logic                      cpu_err,
    output logic [ADDR_W-1:0]         dev_addr,
    output logic [DATA_W-1:0]         dev_wdata,
    output logic [DATA_W/8-1:0]       dev_be,
    output logic                      dev_we,
    output logic [NUM_DEV-1:0]        dev_sel,
    input  logic [NUM_DEV*DATA_W-1:0] dev_rdata,
    input  logic [NUM_DEV-1:0]        dev_ready,
    input  logic [NUM_DEV-1:0]        dev_irq,
    output logic [NUM_DEV-1:0]        hwint
);

    localparam int SEL_W = $clog2(NUM_DEV);

    if (NUM_DEV < 2 || NUM_DEV > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("multi_dev_bridge: NUM_DEV must be 2..8, TIMEOUT_CYC >= 1");
    end

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  idx_q, idx_in;
    logic              we_q;
    logic              in_range;
    logic              load, finish, fin_err;
    logic [DATA_W-1:0] fin_data;

`ifdef BRIDGE_TIMEOUT_EN
    logic wd_en, wd_expired;

    bridge_wdog #(.LIMIT(TIMEOUT_CYC)) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (load),
        .en      (wd_en),
        .expired (wd_expired)
    );
`endif

    assign idx_in   = cpu_addr[SEL_LSB +: SEL_W];
    assign in_range = (32'(idx_in) < NUM_DEV);

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        finish   = 1'b0;
        fin_err  = 1'b0;
        fin_data = '0;
`ifdef BRIDGE_TIMEOUT_EN
        wd_en    = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    load = 1'b1;
                    if (in_range) begin
                        state_d = ACCESS;
                    end else begin
                        state_d = RESP;
                        finish  = 1'b1;
                        fin_err = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (dev_ready[idx_q]) begin
                    state_d = RESP;
                    finish  = 1'b1;
                    if (!we_q) fin_data = dev_rdata[idx_q*DATA_W +: DATA_W];
                end
`ifdef BRIDGE_TIMEOUT_EN
                else if (wd_expired) begin
                    state_d = RESP;
                    finish  = 1'b1;
                    fin_err = 1'b1;
                end else begin
                    wd_en = 1'b1;
                end
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dev_addr  <= '0;
            dev_wdata <= '0;
            dev_be    <= '0;
            we_q      <= 1'b0;
            idx_q     <= '0;
            cpu_rdata <= '0;
            cpu_err   <= 1'b0;
            hwint     <= '0;
        end else begin
            if (load) begin
                dev_addr  <= cpu_addr;
                dev_wdata <= cpu_wdata;
                dev_be    <= cpu_be;
                we_q      <= cpu_we;
                idx_q     <= idx_in;
            end
            if (finish) begin
                cpu_rdata <= fin_data;
                cpu_err   <= fin_err;
            end
            hwint <= dev_irq;
        end
    end

    // Decoded straight from state so an async reset drops the select at once
    assign dev_sel = (state_q == ACCESS) ? (NUM_DEV'(1) << idx_q) : '0;
    assign dev_we  = (state_q == ACCESS) && we_q;
    assign cpu_ack = (state_q == RESP);

endmodule

// File: tb/tb_multi_dev_bridge.sv
// Directed scoreboard bench for multi_dev_bridge (default 3 devices, 32-bit).
// Timeout steps follow whether BRIDGE_TIMEOUT_EN is defined.
module tb_multi_dev_bridge;

    localparam int ND = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we;
    logic [3:0]    cpu_be;
    logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
    logic          cpu_ack, cpu_err;
    logic [31:0]   dev_addr, dev_wdata;
    logic [3:0]    dev_be;
    logic          dev_we;
    logic [ND-1:0] dev_sel, dev_ready, dev_irq, hwint;
    logic [ND*32-1:0] dev_rdata;

    int vectors = 0;
    int miscompares = 0;
    int ready_dly = 0;
    int sel_cycles = 0;
    logic [ND-1:0] noise = '0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];

    multi_dev_bridge dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_be    (cpu_be),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .cpu_err   (cpu_err),
        .dev_addr  (dev_addr),
        .dev_wdata (dev_wdata),
        .dev_be    (dev_be),
        .dev_we    (dev_we),
        .dev_sel   (dev_sel),
        .dev_rdata (dev_rdata),
        .dev_ready (dev_ready),
        .dev_irq   (dev_irq),
        .hwint     (hwint)
    );

    always #5 clk = ~clk;

    assign dev_rdata = {32'hCAFE_0002, 32'hDEAD_BEEF, 32'h0BAD_F00D};

    always @(posedge clk) begin
        if (|dev_sel) sel_cycles <= sel_cycles + 1;
        else          sel_cycles <= 0;
    end

    always_comb begin
        dev_ready = noise;
        if (sel_cycles >= ready_dly) dev_ready = dev_ready | dev_sel;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [ND-1:0] exp_sel,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input int exp_lat);
        exp_t e;
        int lat;
        sb.push_back('{exp_rdata, exp_err, exp_lat});
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_be    = be;
        lat = 0;
        do begin
            tick();
            lat++;
            if (!cpu_ack && dev_sel != '0) begin
                chk("access_sel", dev_sel, exp_sel);
                chk("access_we", dev_we, we);
                chk("access_addr", dev_addr, addr);
                if (we) chk("access_wdata", dev_wdata, wdata);
            end
        end while (!cpu_ack && lat < 100);
        cpu_req = 1'b0;
        e = sb.pop_front();
        chk("ack_seen", cpu_ack, 1'b1);
        chk("latency", lat, e.lat);
        chk("rdata", cpu_rdata, e.rdata);
        chk("err", cpu_err, e.err);
        chk("resp_sel", dev_sel, '0);
        chk("resp_we", dev_we, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: observed hang expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        reset     = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_be    = '0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        dev_irq   = 3'b111;
        repeat (2) tick();
        chk("rst_ack", cpu_ack, 1'b0);
        chk("rst_err", cpu_err, 1'b0);
        chk("rst_sel", dev_sel, '0);
        chk("rst_we", dev_we, 1'b0);
        chk("rst_hwint", hwint, '0);
        chk("rst_rdata", cpu_rdata, '0);
        chk("rst_addr", dev_addr, '0);
        chk("rst_wdata", dev_wdata, '0);
        chk("rst_be", dev_be, '0);
        dev_irq = '0;
        reset = 1'b0;
        tick();

        // Minimum-latency read from device 1
        ready_dly = 0;
        txn(1'b0, 32'h0000_0010, 32'h0, 4'hF, 3'b010, 32'hDEAD_BEEF, 1'b0, 2);
        tick();
        chk("ack_pulse", cpu_ack, 1'b0);
        tick();
        chk("hold_rdata", cpu_rdata, 32'hDEAD_BEEF);
        chk("hold_err", cpu_err, 1'b0);

        // Write to device 0, two ACCESS cycles
        ready_dly = 1;
        txn(1'b1, 32'h0000_0004, 32'h1234_5678, 4'hF, 3'b001, 32'h0, 1'b0, 3);
        chk("w_dev_wdata", dev_wdata, 32'h1234_5678);
        chk("w_dev_be", dev_be, 4'hF);
        tick();
        chk("w_idle_we", dev_we, 1'b0);

        // Read device 2, then an out-of-range index back-to-back
        ready_dly = 0;
        txn(1'b0, 32'h0000_0020, 32'h0, 4'h3, 3'b100, 32'hCAFE_0002, 1'b0, 2);
        txn(1'b0, 32'h0000_0030, 32'h0, 4'hF, 3'b000, 32'h0, 1'b1, 2);
        tick();
        chk("err_hold", cpu_err, 1'b1);

        // Foreign ready lines must not complete a device-0 access
        ready_dly = 2;
        noise = 3'b110;
        txn(1'b0, 32'h0000_0000, 32'h0, 4'hF, 3'b001, 32'h0BAD_F00D, 1'b0, 4);
        noise = '0;
        tick();

`ifdef BRIDGE_TIMEOUT_EN
        ready_dly = 1000;
        txn(1'b0, 32'h0000_0020, 32'h0, 4'hF, 3'b100, 32'h0, 1'b1, 16);
        tick();
        ready_dly = 14;
        txn(1'b0, 32'h0000_0020, 32'h0, 4'hF, 3'b100, 32'hCAFE_0002, 1'b0, 16);
        tick();
`else
        ready_dly = 20;
        txn(1'b0, 32'h0000_0020, 32'h0, 4'hF, 3'b100, 32'hCAFE_0002, 1'b0, 22);
        tick();
`endif

        // Reset in the middle of a stalled access
        ready_dly = 1000;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_0020;
        repeat (3) tick();
        chk("mid_sel", dev_sel, 3'b100);
        cpu_req = 1'b0;
        reset = 1'b1;
        #1;
        chk("arst_sel", dev_sel, '0);
        chk("arst_ack", cpu_ack, 1'b0);
        chk("arst_rdata", cpu_rdata, '0);
        chk("arst_addr", dev_addr, '0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_ack", cpu_ack, 1'b0);
        ready_dly = 0;
        txn(1'b0, 32'h0000_0010, 32'h0, 4'hF, 3'b010, 32'hDEAD_BEEF, 1'b0, 2);
        tick();

        // Interrupt lines pass through one register stage
        dev_irq = 3'b101;
        #1;
        chk("irq_pre", hwint, 3'b000);
        tick();
        chk("irq_post", hwint, 3'b101);
        dev_irq = 3'b010;
        tick();
        chk("irq_next", hwint, 3'b010);

        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
